// File: rtl/cdb_broadcaster.sv
// cdb_broadcaster
//   Collects results from two functional units into a small circular queue
//   and broadcasts them, one per cycle, to the reservation stations on the
//   common data bus.
//
// Ports
//   clk, rst                 single clock, asynchronous active-high reset
//   fu0_valid_IN/tag/data    result offered by functional unit 0
//   fu0_ready_OUT            FU0 result taken at this edge if valid
//   fu1_valid_IN/tag/data    result offered by functional unit 1
//   fu1_ready_OUT            FU1 result taken at this edge if valid
//   bcast_stall_IN           reservation stations cannot take a broadcast
//   bcast_OUT                one-cycle broadcast strobe
//   bcast_tag_OUT/data_OUT   head entry while bcast_OUT=1, zero otherwise
//   count_OUT                number of queued results
//   full_OUT, empty_OUT      queue status
//
// Handshake: a producer transfer happens at a rising edge exactly when
// valid and ready are both high in the cycle before it. Ready never looks at
// this cycle's pop, so a full queue refuses results even while it drains.
// On the output side bcast_OUT is itself the transfer strobe; the consumer
// back-pressures with bcast_stall_IN and the head entry stays put meanwhile.

module cdb_broadcaster #(
  parameter int tag_width  = 8,
  parameter int data_width = 128,
  parameter int depth      = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   fu0_valid_IN,
  input  logic [tag_width-1:0]   fu0_tag_IN,
  input  logic [data_width-1:0]  fu0_data_IN,
  output logic                   fu0_ready_OUT,
  input  logic                   fu1_valid_IN,
  input  logic [tag_width-1:0]   fu1_tag_IN,
  input  logic [data_width-1:0]  fu1_data_IN,
  output logic                   fu1_ready_OUT,
  input  logic                   bcast_stall_IN,
  output logic                   bcast_OUT,
  output logic [tag_width-1:0]   bcast_tag_OUT,
  output logic [data_width-1:0]  bcast_data_OUT,
  output logic [$clog2(depth):0] count_OUT,
  output logic                   full_OUT,
  output logic                   empty_OUT
);

  localparam int ptr_w = $clog2(depth);
  localparam int cnt_w = ptr_w + 1;

  logic [tag_width-1:0]  tag_mem  [depth];
  logic [data_width-1:0] data_mem [depth];
  logic [ptr_w-1:0]      head;
  logic [ptr_w-1:0]      tail;
  logic [cnt_w-1:0]      count;
  // Round-robin priority: 0 favours FU0, 1 favours FU1.
  logic                  rr;

  logic                  full;
  logic                  empty;
  logic                  grant0;
  logic                  grant1;
  logic                  push;
  logic                  pop;
  logic [tag_width-1:0]  push_tag;
  logic [data_width-1:0] push_data;

  assign full  = (count == cnt_w'(depth));
  assign empty = (count == '0);

  // The two readies can only both be high when at most one FU is valid,
  // so grant0 and grant1 are mutually exclusive.
  assign fu0_ready_OUT = ~full & (~rr | ~fu1_valid_IN);
  assign fu1_ready_OUT = ~full & ( rr | ~fu0_valid_IN);
  assign grant0        = fu0_valid_IN & fu0_ready_OUT;
  assign grant1        = fu1_valid_IN & fu1_ready_OUT;
  assign push          = grant0 | grant1;
  assign push_tag      = grant1 ? fu1_tag_IN  : fu0_tag_IN;
  assign push_data     = grant1 ? fu1_data_IN : fu0_data_IN;

  assign bcast_OUT      = ~empty & ~bcast_stall_IN;
  assign pop            = bcast_OUT;
  assign bcast_tag_OUT  = bcast_OUT ? tag_mem[head]  : '0;
  assign bcast_data_OUT = bcast_OUT ? data_mem[head] : '0;

  assign count_OUT = count;
  assign full_OUT  = full;
  assign empty_OUT = empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      rr    <= 1'b0;
      for (int i = 0; i < depth; i++) begin
        tag_mem[i]  <= '0;
        data_mem[i] <= '0;
      end
    end else begin
      if (push) begin
        tag_mem[tail]  <= push_tag;
        data_mem[tail] <= push_data;
        // Pointers are exactly ptr_w bits wide, so +1 wraps at depth.
        tail           <= tail + 1'b1;
        // Hand priority to the port that was not just served.
        rr             <= grant0;
      end
      if (pop) begin
        head <= head + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_cdb_broadcaster.sv
// tb_cdb_broadcaster
//   Drives cdb_broadcaster with directed scenarios and random traffic and
//   compares every output against a queue-based reference model.

module tb_cdb_broadcaster;

  localparam int TW    = 8;
  localparam int DW    = 128;
  localparam int DEPTH = 4;
  localparam int EW    = TW + DW;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic          fu0_valid, fu1_valid, stall;
  logic [TW-1:0] fu0_tag, fu1_tag;
  logic [DW-1:0] fu0_data, fu1_data;
  logic          fu0_ready, fu1_ready, bcast, full, empty;
  logic [TW-1:0] bcast_tag;
  logic [DW-1:0] bcast_data;
  logic [$clog2(DEPTH):0] count;

  cdb_broadcaster #(.tag_width(TW), .data_width(DW), .depth(DEPTH)) dut (
    .clk            (clk),
    .rst            (rst),
    .fu0_valid_IN   (fu0_valid),
    .fu0_tag_IN     (fu0_tag),
    .fu0_data_IN    (fu0_data),
    .fu0_ready_OUT  (fu0_ready),
    .fu1_valid_IN   (fu1_valid),
    .fu1_tag_IN     (fu1_tag),
    .fu1_data_IN    (fu1_data),
    .fu1_ready_OUT  (fu1_ready),
    .bcast_stall_IN (stall),
    .bcast_OUT      (bcast),
    .bcast_tag_OUT  (bcast_tag),
    .bcast_data_OUT (bcast_data),
    .count_OUT      (count),
    .full_OUT       (full),
    .empty_OUT      (empty)
  );

  // ---------------- scoreboard / reference model ----------------
  logic [EW-1:0] exp_q[$];     // accepted results in acceptance order
  logic          m_turn_fu1;   // model: FU1 has priority on contention
  logic          acc0, acc1;   // model: which FU was accepted last step
  int            n_checks = 0;
  int            n_fail   = 0;

  task automatic check(input string name, input logic [EW-1:0] obs,
                       input logic [EW-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, obs, exp, $time);
    end
  endtask

  // ---------------- driver ----------------
  // One clock cycle: drive inputs after the falling edge, compare all outputs
  // against the model, then advance the model to the state after the next
  // rising edge.
  task automatic step(input logic v0, input logic [TW-1:0] t0,
                      input logic [DW-1:0] d0, input logic v1,
                      input logic [TW-1:0] t1, input logic [DW-1:0] d1,
                      input logic st);
    bit q_full, q_empty, e_r0, e_r1, e_b;
    logic [EW-1:0] e_out;
    @(negedge clk);
    fu0_valid = v0; fu0_tag = t0; fu0_data = d0;
    fu1_valid = v1; fu1_tag = t1; fu1_data = d1;
    stall = st;
    #1;
    q_full  = (exp_q.size() == DEPTH);
    q_empty = (exp_q.size() == 0);
    // A single FU is served whenever there is room; on contention the
    // priority holder wins.
    e_r0  = !q_full && (!m_turn_fu1 || !v1);
    e_r1  = !q_full && ( m_turn_fu1 || !v0);
    e_b   = !q_empty && !st;
    e_out = e_b ? exp_q[0] : '0;
    check("fu0_ready", EW'(fu0_ready), EW'(e_r0));
    check("fu1_ready", EW'(fu1_ready), EW'(e_r1));
    check("bcast",     EW'(bcast),     EW'(e_b));
    check("bcast_ent", {bcast_tag, bcast_data}, e_out);
    check("count",     EW'(count),     EW'(exp_q.size()));
    check("full",      EW'(full),      EW'(q_full));
    check("empty",     EW'(empty),     EW'(q_empty));
    acc0 = v0 && e_r0;
    acc1 = v1 && e_r1;
    if (e_b) void'(exp_q.pop_front());
    if (acc0) begin exp_q.push_back({t0, d0}); m_turn_fu1 = 1'b1; end
    if (acc1) begin exp_q.push_back({t1, d1}); m_turn_fu1 = 1'b0; end
  endtask

  task automatic idle(input logic st);
    step(1'b0, '0, '0, 1'b0, '0, '0, st);
  endtask

  // Asynchronous reset: outputs must clear before any clock edge.
  task automatic do_reset();
    @(negedge clk);
    fu0_valid = 1'b0; fu1_valid = 1'b0; stall = 1'b0;
    fu0_tag = '0; fu1_tag = '0; fu0_data = '0; fu1_data = '0;
    rst = 1'b1;
    #1;
    check("rst_bcast", EW'(bcast), '0);
    check("rst_ent",   {bcast_tag, bcast_data}, '0);
    check("rst_count", EW'(count), '0);
    check("rst_empty", EW'(empty), EW'(1));
    check("rst_full",  EW'(full),  '0);
    check("rst_rdy0",  EW'(fu0_ready), EW'(1));
    check("rst_rdy1",  EW'(fu1_ready), EW'(1));
    exp_q.delete();
    m_turn_fu1 = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  function automatic logic [DW-1:0] rand_data();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    int i0, i1, n;
    logic [TW-1:0] tg;
    fu0_valid = 1'b0; fu1_valid = 1'b0; stall = 1'b0;
    fu0_tag = '0; fu1_tag = '0; fu0_data = '0; fu1_data = '0;
    m_turn_fu1 = 1'b0;
    rst = 1'b1;
    #1;
    do_reset();

    // Single result, tag 0 included later in random traffic.
    step(1'b1, 8'h05, DW'(8'hAA), 1'b0, '0, '0, 1'b0);
    idle(1'b0);
    check("single_tag",  EW'(bcast_tag),  EW'(8'h05));
    check("single_data", EW'(bcast_data), EW'(8'hAA));
    idle(1'b0);
    check("single_empty", EW'(empty), EW'(1));

    // Contention: both units hold their current result until accepted.
    i0 = 0; i1 = 0;
    for (int c = 0; c < 10; c++) begin
      step(1'b1, TW'(8'h10 + i0), rand_data(), 1'b1, TW'(8'h20 + i1), rand_data(), 1'b0);
      if (acc0) i0++;
      if (acc1) i1++;
    end
    check("contend_fu0_n", EW'(i0), EW'(5));
    check("contend_fu1_n", EW'(i1), EW'(5));
    repeat (5) idle(1'b0);

    // Fill under stall, fifth result waits, then drain.
    for (int k = 1; k <= 4; k++) step(1'b1, TW'(k), rand_data(), 1'b0, '0, '0, 1'b1);
    step(1'b1, 8'h05, rand_data(), 1'b0, '0, '0, 1'b1);
    check("fill_count", EW'(count), EW'(4));
    check("fill_full",  EW'(full),  EW'(1));
    check("fill_rdy0",  EW'(fu0_ready), '0);
    n = 0;
    while (!acc0 && n < 20) begin
      step(1'b1, 8'h05, rand_data(), 1'b0, '0, '0, 1'b0);
      n++;
    end
    check("fill_fifth_taken", EW'(acc0), EW'(1));
    repeat (6) idle(1'b0);

    // Full with pop: no push that cycle, push on the next one.
    for (int k = 0; k < 4; k++) step(1'b1, TW'(8'h30 + k), rand_data(), 1'b0, '0, '0, 1'b1);
    step(1'b0, '0, '0, 1'b1, 8'h40, rand_data(), 1'b0);
    check("fullpop_norush", EW'(acc1), '0);
    step(1'b0, '0, '0, 1'b1, 8'h40, rand_data(), 1'b0);
    check("fullpop_count3", EW'(count), EW'(3));
    check("fullpop_taken",  EW'(acc1), EW'(1));
    idle(1'b0);
    check("fullpop_count3b", EW'(count), EW'(3));
    repeat (5) idle(1'b0);

    // Wrap-around: ten results with interleaved stalls.
    tg = 8'h50;
    n = 0;
    while (tg < 8'h5A && n < 200) begin
      step(1'b1, tg, rand_data(), 1'b0, '0, '0, 1'($urandom_range(0, 2) == 0));
      if (acc0) tg++;
      n++;
    end
    check("wrap_all_taken", EW'(tg), EW'(8'h5A));
    repeat (8) idle(1'($urandom_range(0, 1)));
    repeat (5) idle(1'b0);
    check("wrap_drained", EW'(empty), EW'(1));

    // Reset mid-stream with three queued results.
    for (int k = 0; k < 3; k++) step(1'b1, TW'(8'h60 + k), rand_data(), 1'b0, '0, '0, 1'b1);
    do_reset();
    step(1'b1, 8'h33, rand_data(), 1'b0, '0, '0, 1'b0);
    idle(1'b0);
    check("post_rst_tag", EW'(bcast_tag), EW'(8'h33));
    idle(1'b0);

    // Random traffic, with an occasional reset.
    for (int c = 0; c < 400; c++) begin
      if (c == 200) do_reset();
      step(1'($urandom_range(0, 9) < 6), TW'($urandom), rand_data(),
           1'($urandom_range(0, 9) < 6), TW'($urandom), rand_data(),
           1'($urandom_range(0, 9) < 3));
    end
    repeat (8) idle(1'b0);
    check("final_empty", EW'(empty), EW'(1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
